// File: rtl/camera_csi2_pkg.sv
// Shared constants, packet header layout and receiver state encoding for the CSI-2 front end.
package camera_csi2_pkg;

    localparam logic [7:0] SYNC_BYTE          = 8'hB8;
    localparam logic [5:0] LONG_PACKET_MIN_DT = 6'h10;

    localparam logic [5:0] DT_GENERIC_SHORT = 6'h08;
    localparam logic [5:0] DT_YUV420_8      = 6'h18;
    localparam logic [5:0] DT_RAW8          = 6'h2A;

    typedef struct packed {
        logic [1:0]  vc;
        logic [5:0]  dt;
        logic [15:0] wc;
        logic [7:0]  ecc;
    } packet_header_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HEADER,
        ST_PAYLOAD,
        ST_CRC
    } rx_state_e;

endpackage

// File: rtl/camera_dphy_lane.sv
// One HS data lane: DDR sampling, zero-run armed sync search and byte framing.
// byte_vld_o/sync_o are registered on the edge that captures the final bit; free-running, no backpressure.
module camera_dphy_lane
    import camera_csi2_pkg::*;
#(
    parameter int ZW = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       data_i,
    input  logic       drop_i,
    output logic [7:0] byte_o,
    output logic       byte_vld_o,
    output logic       sync_o,
    output logic       sync_phase_o
);

    logic          neg_q;
    logic [7:0]    win_q, win_d;
    logic [7:0]    hist_q, hist_d;
    logic [7:0]    byte_q, byte_d;
    logic [ZW-1:0] zc_q, zc_d;
    logic [2:0]    cnt_q, cnt_d;
    logic          aligned_q, aligned_d;
    logic          vld_q, vld_d;
    logic          sync_q, sync_d;
    logic          phase_q, phase_d;
    logic [1:0]    bits;

    always_ff @(negedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            neg_q <= 1'b0;
        end else begin
            neg_q <= data_i;
        end
    end

    // hist_d tracks, per window position, whether the zero run was saturated
    // just before that bit; hist_d[0] therefore covers the first sync bit.
    always_comb begin
        win_d     = win_q;
        hist_d    = hist_q;
        zc_d      = zc_q;
        cnt_d     = cnt_q;
        aligned_d = aligned_q;
        byte_d    = byte_q;
        vld_d     = 1'b0;
        sync_d    = 1'b0;
        phase_d   = 1'b0;
        bits      = {data_i, neg_q};
        for (int i = 0; i < 2; i++) begin
            hist_d = {&zc_d, hist_d[7:1]};
            win_d  = {bits[i], win_d[7:1]};
            if (aligned_d) begin
                cnt_d = cnt_d + 3'd1;
                if (cnt_d == 3'd0) begin
                    byte_d = win_d;
                    vld_d  = 1'b1;
                end
            end else begin
                if (bits[i]) begin
                    zc_d = '0;
                end else if (!(&zc_d)) begin
                    zc_d = zc_d + ZW'(1);
                end
                if (win_d == SYNC_BYTE && hist_d[0]) begin
                    aligned_d = 1'b1;
                    cnt_d     = '0;
                    zc_d      = '0;
                    hist_d    = '0;
                    sync_d    = 1'b1;
                    phase_d   = (i == 1);
                end
            end
        end
        if (drop_i) begin
            aligned_d = 1'b0;
            zc_d      = '0;
            hist_d    = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            win_q     <= '0;
            hist_q    <= '0;
            zc_q      <= '0;
            cnt_q     <= '0;
            aligned_q <= 1'b0;
            byte_q    <= '0;
            vld_q     <= 1'b0;
            sync_q    <= 1'b0;
            phase_q   <= 1'b0;
        end else begin
            win_q     <= win_d;
            hist_q    <= hist_d;
            zc_q      <= zc_d;
            cnt_q     <= cnt_d;
            aligned_q <= aligned_d;
            byte_q    <= byte_d;
            vld_q     <= vld_d;
            sync_q    <= sync_d;
            phase_q   <= phase_d;
        end
    end

    assign byte_o       = byte_q;
    assign byte_vld_o   = vld_q;
    assign sync_o       = sync_q;
    assign sync_phase_o = phase_q;

endmodule

// File: rtl/camera_csi2_rx.sv
// CSI-2 receiver: lane merge, header parse and payload packing into 32-bit words.
// Strobes registered one cycle after the completing lane byte; no backpressure (sink must keep up).
module camera_csi2_rx
    import camera_csi2_pkg::*;
#(
    parameter int NUM_LANES              = 2,
    parameter int ZERO_ACCUMULATOR_WIDTH = 2
) (
    input  logic                 clock_p,
    input  logic                 reset,
    input  logic [NUM_LANES-1:0] data_p,
    output logic [1:0]           virtual_channel,
    output logic [15:0]          word_count,
    output logic [7:0]           image_data [3:0],
    output logic [5:0]           image_data_type,
    output logic                 image_data_enable,
    output logic                 interrupt
);

    logic [7:0]           lane_byte [NUM_LANES];
    logic [NUM_LANES-1:0] lane_vld, lane_sync, lane_phase;
    logic                 all_sync;

    rx_state_e      state_q, state_d;
    packet_header_t hdr_q, hdr_d;
    logic [15:0]    cnt_q, cnt_d;
    logic [1:0]     widx_q, widx_d;
    logic [7:0]     acc_q [3:0];
    logic [7:0]     acc_d [3:0];
    logic [7:0]     img_q [3:0];
    logic [7:0]     img_d [3:0];
    logic [1:0]     vc_q, vc_d;
    logic [5:0]     dt_q, dt_d;
    logic [15:0]    wc_q, wc_d;
    logic [7:0]     header_ecc, header_ecc_d;
    logic           en_q, en_d, irq_q, irq_d, drop_q, drop_d;

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        camera_dphy_lane #(.ZW(ZERO_ACCUMULATOR_WIDTH)) u_lane (
            .clk_i        (clock_p),
            .rst_i        (reset),
            .data_i       (data_p[l]),
            .drop_i       (drop_q),
            .byte_o       (lane_byte[l]),
            .byte_vld_o   (lane_vld[l]),
            .sync_o       (lane_sync[l]),
            .sync_phase_o (lane_phase[l])
        );
    end

    // Skew-free lanes: every lane must hit sync on the very same DDR sample.
    assign all_sync = (&lane_sync) && ((lane_phase == '0) || (lane_phase == '1));

    always_comb begin
        state_d      = state_q;
        hdr_d        = hdr_q;
        cnt_d        = cnt_q;
        widx_d       = widx_q;
        acc_d        = acc_q;
        img_d        = img_q;
        vc_d         = vc_q;
        dt_d         = dt_q;
        wc_d         = wc_q;
        header_ecc_d = header_ecc;
        en_d         = 1'b0;
        irq_d        = 1'b0;
        drop_d       = 1'b0;
        if (state_q == ST_IDLE) begin
            if (all_sync) begin
                state_d = ST_HEADER;
                cnt_d   = '0;
            end else if (|lane_sync) begin
                drop_d = 1'b1;
            end
        end else if (&lane_vld) begin
            // Lane 0 carries the earliest byte, so walk lanes in order; the state may change mid-group.
            for (int l = 0; l < NUM_LANES; l++) begin
                case (state_d)
                    ST_HEADER: begin
                        case (cnt_d[1:0])
                            2'd0: begin
                                hdr_d.vc = lane_byte[l][7:6];
                                hdr_d.dt = lane_byte[l][5:0];
                            end
                            2'd1:    hdr_d.wc[7:0]  = lane_byte[l];
                            2'd2:    hdr_d.wc[15:8] = lane_byte[l];
                            default: hdr_d.ecc      = lane_byte[l];
                        endcase
                        cnt_d = cnt_d + 16'd1;
                        if (cnt_d == 16'd4) begin
                            vc_d         = hdr_d.vc;
                            dt_d         = hdr_d.dt;
                            wc_d         = hdr_d.wc;
                            header_ecc_d = hdr_d.ecc;
                            irq_d        = 1'b1;
                            cnt_d        = '0;
                            widx_d       = '0;
                            acc_d        = '{default: '0};
                            if (hdr_d.dt < LONG_PACKET_MIN_DT) begin
                                state_d = ST_IDLE;
                                drop_d  = 1'b1;
                            end else if (hdr_d.wc == 16'd0) begin
                                state_d = ST_CRC;
                            end else begin
                                state_d = ST_PAYLOAD;
                            end
                        end
                    end
                    ST_PAYLOAD: begin
                        acc_d[widx_d] = lane_byte[l];
                        cnt_d         = cnt_d + 16'd1;
                        if (widx_d == 2'd3 || cnt_d == hdr_d.wc) begin
                            img_d  = acc_d;
                            en_d   = 1'b1;
                            irq_d  = 1'b1;
                            acc_d  = '{default: '0};
                            widx_d = '0;
                        end else begin
                            widx_d = widx_d + 2'd1;
                        end
                        if (cnt_d == hdr_d.wc) begin
                            state_d = ST_CRC;
                            cnt_d   = '0;
                        end
                    end
                    ST_CRC: begin
                        cnt_d = cnt_d + 16'd1;
                        if (cnt_d == 16'd2) begin
                            state_d = ST_IDLE;
                            drop_d  = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clock_p or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            hdr_q      <= '0;
            cnt_q      <= '0;
            widx_q     <= '0;
            acc_q      <= '{default: '0};
            img_q      <= '{default: '0};
            vc_q       <= '0;
            dt_q       <= '0;
            wc_q       <= '0;
            header_ecc <= '0;
            en_q       <= 1'b0;
            irq_q      <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            hdr_q      <= hdr_d;
            cnt_q      <= cnt_d;
            widx_q     <= widx_d;
            acc_q      <= acc_d;
            img_q      <= img_d;
            vc_q       <= vc_d;
            dt_q       <= dt_d;
            wc_q       <= wc_d;
            header_ecc <= header_ecc_d;
            en_q       <= en_d;
            irq_q      <= irq_d;
            drop_q     <= drop_d;
        end
    end

    assign virtual_channel   = vc_q;
    assign image_data_type   = dt_q;
    assign word_count        = wc_q;
    assign image_data        = img_q;
    assign image_data_enable = en_q;
    assign interrupt         = irq_q;

endmodule

// File: tb/tb_camera_csi2_rx.sv
// Scoreboarded bench: packets are serialized onto DDR lanes, a packet-level model predicts strobes.
module tb_camera_csi2_rx;
    import camera_csi2_pkg::*;

    localparam int NL = 2;

    logic          clock_p = 1'b0;
    logic          reset   = 1'b1;
    logic [NL-1:0] data_p  = '0;
    logic [1:0]    virtual_channel;
    logic [15:0]   word_count;
    logic [7:0]    image_data [3:0];
    logic [5:0]    image_data_type;
    logic          image_data_enable;
    logic          interrupt;

    camera_csi2_rx #(.NUM_LANES(NL), .ZERO_ACCUMULATOR_WIDTH(2)) dut (
        .clock_p           (clock_p),
        .reset             (reset),
        .data_p            (data_p),
        .virtual_channel   (virtual_channel),
        .word_count        (word_count),
        .image_data        (image_data),
        .image_data_type   (image_data_type),
        .image_data_enable (image_data_enable),
        .interrupt         (interrupt)
    );

    initial forever #10 clock_p = ~clock_p;

    typedef struct packed {
        logic        is_word;
        logic [1:0]  vc;
        logic [5:0]  dt;
        logic [15:0] wc;
        logic [7:0]  ecc;
        logic [31:0] word;
    } exp_t;

    exp_t       exp_q [$];
    logic [7:0] pkt_q [$];
    int         total = 0;
    int         bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] img_word();
        return {image_data[3], image_data[2], image_data[1], image_data[0]};
    endfunction

    // Each call holds one DDR bit on every lane until the following clock edge.
    task automatic drive(input logic [NL-1:0] v);
        @(posedge clock_p or negedge clock_p);
        #5;
        data_p = v;
    endtask

    // Zero run, sync byte, then the first nbytes of pkt_q striped across lanes, LSB first.
    task automatic send_stream(input int nbytes);
        logic [7:0] s;
        int groups;
        s = SYNC_BYTE;
        groups = (nbytes + NL - 1) / NL;
        repeat (16) drive('0);
        for (int b = 0; b < 8; b++) drive({NL{s[b]}});
        for (int g = 0; g < groups; g++) begin
            for (int b = 0; b < 8; b++) begin
                logic [NL-1:0] v;
                for (int l = 0; l < NL; l++) begin
                    int k;
                    k = g * NL + l;
                    v[l] = (k < nbytes) ? pkt_q[k][b] : 1'b0;
                end
                drive(v);
            end
        end
    endtask

    // Packet-level model: header event, then one event per 4 payload bytes (last one zero padded).
    task automatic expect_packet();
        exp_t e;
        int   wc;
        e     = '0;
        e.vc  = pkt_q[0][7:6];
        e.dt  = pkt_q[0][5:0];
        e.wc  = {pkt_q[2], pkt_q[1]};
        e.ecc = pkt_q[3];
        exp_q.push_back(e);
        if (e.dt >= 6'h10) begin
            wc = int'(e.wc);
            for (int w = 0; w * 4 < wc; w++) begin
                exp_t d;
                d = '0;
                d.is_word = 1'b1;
                for (int j = 0; j < 4; j++)
                    if (w * 4 + j < wc) d.word[8*j +: 8] = pkt_q[4 + w*4 + j];
                exp_q.push_back(d);
            end
        end
    endtask

    task automatic make_packet(input logic [1:0] vc, input logic [5:0] dt,
                               input logic [15:0] wc, input logic [7:0] ecc);
        pkt_q.delete();
        pkt_q.push_back({vc, dt});
        pkt_q.push_back(wc[7:0]);
        pkt_q.push_back(wc[15:8]);
        pkt_q.push_back(ecc);
        if (dt >= 6'h10) begin
            for (int i = 0; i < int'(wc) + 2; i++) pkt_q.push_back(8'($urandom_range(0, 255)));
        end
    endtask

    task automatic run_packet();
        expect_packet();
        send_stream(pkt_q.size());
        repeat (24) drive('0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_irq"}, 32'(interrupt), 32'd0);
        check({tag, "_en"},  32'(image_data_enable), 32'd0);
        check({tag, "_vc"},  32'(virtual_channel), 32'd0);
        check({tag, "_dt"},  32'(image_data_type), 32'd0);
        check({tag, "_wc"},  32'(word_count), 32'd0);
        check({tag, "_ecc"}, 32'(dut.header_ecc), 32'd0);
        check({tag, "_img"}, img_word(), 32'd0);
    endtask

    // Monitor: pops one expectation per strobe cycle.
    initial begin
        logic prev_irq, prev_en;
        exp_t e;
        prev_irq = 1'b0;
        prev_en  = 1'b0;
        forever begin
            @(negedge clock_p);
            if (reset) begin
                prev_irq = 1'b0;
                prev_en  = 1'b0;
            end else begin
                if (interrupt || image_data_enable) begin
                    check("strobe_spacing", 32'({prev_irq & interrupt, prev_en & image_data_enable}), 32'd0);
                    if (exp_q.size() == 0) begin
                        check("unexpected_strobe", 32'({interrupt, image_data_enable}), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("interrupt", 32'(interrupt), 32'd1);
                        check("image_data_enable", 32'(image_data_enable), 32'(e.is_word));
                        if (e.is_word) begin
                            check("image_data", img_word(), e.word);
                        end else begin
                            check("virtual_channel", 32'(virtual_channel), 32'(e.vc));
                            check("image_data_type", 32'(image_data_type), 32'(e.dt));
                            check("word_count", 32'(word_count), 32'(e.wc));
                            check("header_ecc", 32'(dut.header_ecc), 32'(e.ecc));
                        end
                    end
                end
                prev_irq = interrupt;
                prev_en  = image_data_enable;
            end
        end
    end

    initial begin
        repeat (3) @(posedge clock_p);
        #1;
        check_outputs_zero("reset");
        reset = 1'b0;
        repeat (8) drive('0);

        // Short packet.
        pkt_q = '{{2'd0, DT_GENERIC_SHORT}, 8'hCE, 8'hFA, 8'h12};
        run_packet();

        // Long packet, two full words.
        pkt_q = '{{2'd0, DT_YUV420_8}, 8'h08, 8'h00, 8'hFE,
                  8'hAD, 8'hDE, 8'hE1, 8'hFE, 8'h5E, 8'hEA, 8'h15, 8'h0D, 8'hD0, 8'hF0};
        run_packet();

        // WC=5: second word zero padded.
        pkt_q = '{{2'd1, DT_YUV420_8}, 8'h05, 8'h00, 8'h77,
                  8'h11, 8'h22, 8'h33, 8'h44, 8'hA5, 8'h9C, 8'h3B};
        run_packet();

        // WC=0 long packet goes straight to CRC.
        pkt_q = '{{2'd3, DT_RAW8}, 8'h00, 8'h00, 8'h42, 8'h12, 8'h34};
        run_packet();

        // Sync byte after a toggling preamble must not align.
        begin
            logic [7:0] s;
            s = SYNC_BYTE;
            for (int i = 0; i < 16; i++) drive((i % 2 == 1) ? '1 : '0);
            for (int b = 0; b < 8; b++) drive({NL{s[b]}});
            repeat (32) drive('1);
            repeat (24) drive('0);
        end

        // Reset in the middle of the payload.
        pkt_q.delete();
        pkt_q = '{{2'd2, DT_RAW8}, 8'h10, 8'h00, 8'h5A};
        for (int i = 1; i <= 18; i++) pkt_q.push_back(8'(i));
        expect_packet();
        while (exp_q.size() > 2) void'(exp_q.pop_back());
        send_stream(8);
        repeat (8) drive('0);
        check("pre_reset_pending", 32'(exp_q.size()), 32'd0);
        reset = 1'b1;
        #1;
        check_outputs_zero("midreset");
        repeat (3) @(posedge clock_p);
        #3;
        reset = 1'b0;
        pkt_q = '{8'h81, 8'h34, 8'h12, 8'h3C};
        run_packet();

        // Randomized mix of short and long packets.
        for (int n = 0; n < 10; n++) begin
            logic [1:0]  vc;
            logic [5:0]  dt;
            logic [15:0] wc;
            vc = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0) begin
                dt = 6'($urandom_range(0, 15));
                wc = 16'($urandom_range(0, 65535));
            end else begin
                dt = ($urandom_range(0, 1) == 0) ? DT_RAW8 : 6'($urandom_range(16, 63));
                wc = 16'($urandom_range(0, 13));
            end
            make_packet(vc, dt, wc, 8'($urandom_range(0, 255)));
            run_packet();
        end

        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clock_p);
        check("drain", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
